level_ctrl: RTL and testbench

Preemption level controller. Drives the `level`, `writeRaEn` and `writeRaData` inputs of `rf_stack`, and the PC-load path of the fetch stage. On an accepted interrupt it pushes the current level and the interrupted PC, then raises `level` and plants the magic return value in `ra` of the new bank. When the handler returns, it pops the stack and restores both the level and the PC.

---
 rtl/level_ctrl.sv | 173 +++++++++++++++++
 tb/tb_level_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/level_ctrl.sv
// level_ctrl -- preemption level controller.
//
// Tracks the current priority level and a stack of interrupted contexts.
// An accepted interrupt pushes {level, pc}, raises the level, writes the
// return magic value into ra of the new register bank and redirects fetch
// to the handler vector. A handler return pops the stack and restores both
// the level and the PC.
//
// Optional feature (macro LEVEL_CTRL_TAIL_CHAIN_EN): a return that meets a
// pending interrupt with priority above the level being popped goes straight
// to the new handler, keeping the stacked context in place.
//
// Ports:
//   clk          core clock
//   reset        asynchronous active-low reset
//   irqReq       pending interrupt request (level-held)
//   irqPrio      priority of pending request
//   irqVector    handler address of pending request
//   irqAck       one-cycle pulse, request accepted
//   pc           PC of next instruction in the interrupted context
//   retReq       one-cycle pulse, handler returned
//   level        current level to rf_stack
//   writeRaEn    ra write strobe to rf_stack
//   writeRaData  ra write value to rf_stack
//   pcLoadEn     one-cycle pulse, fetch loads pcLoadData
//   pcLoadData   target PC
//   depth        number of stacked contexts
//   retErr       one-cycle pulse, return with nothing stacked
module level_ctrl #(
  parameter int                   DataWidth   = 32,
  parameter int                   NumLevels   = 8,
  parameter logic [DataWidth-1:0] RaMagic     = 'hFFFF_FFF0,
  localparam int                  IndexLevels = $clog2(NumLevels)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   irqReq,
  input  logic [IndexLevels-1:0] irqPrio,
  input  logic [DataWidth-1:0]   irqVector,
  output logic                   irqAck,
  input  logic [DataWidth-1:0]   pc,
  input  logic                   retReq,
  output logic [IndexLevels-1:0] level,
  output logic                   writeRaEn,
  output logic [DataWidth-1:0]   writeRaData,
  output logic                   pcLoadEn,
  output logic [DataWidth-1:0]   pcLoadData,
  output logic [IndexLevels-1:0] depth,
  output logic                   retErr
);

  typedef enum logic [1:0] {RUN, ENTER, EXIT} state_t;

  state_t state, state_nxt;

  // Context stack; only depth is reset, contents are don't-care.
  logic [IndexLevels-1:0] stack_lvl [NumLevels-1];
  logic [DataWidth-1:0]   stack_pc  [NumLevels-1];

  // Target of the pending ENTER/EXIT: new prio/vector or popped level/pc.
  logic [IndexLevels-1:0] lat_lvl, lat_lvl_nxt;
  logic [DataWidth-1:0]   lat_addr, lat_addr_nxt;

  logic [IndexLevels-1:0] level_nxt, depth_nxt, pop_idx;
  logic                   ack_nxt, err_nxt, wra_en_nxt, pcl_en_nxt, push;
  logic [DataWidth-1:0]   wra_data_nxt, pcl_data_nxt;

  assign pop_idx = depth - IndexLevels'(1);

  always_comb begin
    state_nxt    = state;
    level_nxt    = level;
    depth_nxt    = depth;
    ack_nxt      = 1'b0;
    err_nxt      = 1'b0;
    wra_en_nxt   = 1'b0;
    wra_data_nxt = writeRaData;
    pcl_en_nxt   = 1'b0;
    pcl_data_nxt = pcLoadData;
    lat_lvl_nxt  = lat_lvl;
    lat_addr_nxt = lat_addr;
    push         = 1'b0;
    case (state)
      RUN: begin
        if (retReq) begin
          // A return wins over a simultaneous request.
          if (depth != '0) begin
`ifdef LEVEL_CTRL_TAIL_CHAIN_EN
            if (irqReq && (irqPrio > stack_lvl[pop_idx])) begin
              // Chain into the new handler; the stacked context remains
              // the one to resume when this handler returns.
              lat_lvl_nxt  = irqPrio;
              lat_addr_nxt = irqVector;
              ack_nxt      = 1'b1;
              state_nxt    = ENTER;
            end else begin
              depth_nxt    = pop_idx;
              lat_lvl_nxt  = stack_lvl[pop_idx];
              lat_addr_nxt = stack_pc[pop_idx];
              state_nxt    = EXIT;
            end
`else
            depth_nxt    = pop_idx;
            lat_lvl_nxt  = stack_lvl[pop_idx];
            lat_addr_nxt = stack_pc[pop_idx];
            state_nxt    = EXIT;
`endif
          end else begin
            err_nxt = 1'b1;
          end
        end else if (irqReq && (irqPrio > level)) begin
          // Strictly increasing levels bound depth to NumLevels-1, and
          // priority 0 can never exceed the current level.
          push         = 1'b1;
          depth_nxt    = depth + IndexLevels'(1);
          lat_lvl_nxt  = irqPrio;
          lat_addr_nxt = irqVector;
          ack_nxt      = 1'b1;
          state_nxt    = ENTER;
        end
      end
      ENTER: begin
        level_nxt    = lat_lvl;
        wra_en_nxt   = 1'b1;
        wra_data_nxt = RaMagic;
        pcl_en_nxt   = 1'b1;
        pcl_data_nxt = lat_addr;
        state_nxt    = RUN;
      end
      EXIT: begin
        level_nxt    = lat_lvl;
        pcl_en_nxt   = 1'b1;
        pcl_data_nxt = lat_addr;
        state_nxt    = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      level       <= '0;
      depth       <= '0;
      irqAck      <= 1'b0;
      retErr      <= 1'b0;
      writeRaEn   <= 1'b0;
      writeRaData <= '0;
      pcLoadEn    <= 1'b0;
      pcLoadData  <= '0;
    end else begin
      state       <= state_nxt;
      level       <= level_nxt;
      depth       <= depth_nxt;
      irqAck      <= ack_nxt;
      retErr      <= err_nxt;
      writeRaEn   <= wra_en_nxt;
      writeRaData <= wra_data_nxt;
      pcLoadEn    <= pcl_en_nxt;
      pcLoadData  <= pcl_data_nxt;
    end
  end

  always_ff @(posedge clk) begin
    lat_lvl  <= lat_lvl_nxt;
    lat_addr <= lat_addr_nxt;
    if (push) begin
      stack_lvl[depth] <= level;
      stack_pc[depth]  <= pc;
    end
  end

endmodule

// File: tb/tb_level_ctrl.sv
// Testbench for level_ctrl: directed steps followed by randomized
// interrupt/return traffic, checked against a stack-of-contexts model.
module tb_level_ctrl;

  localparam int          DW    = 32;
  localparam int          NL    = 8;
  localparam int          IL    = $clog2(NL);
  localparam logic [31:0] MAGIC = 32'hFFFF_FFF0;

  logic          clk = 1'b0;
  logic          reset;
  logic          irqReq;
  logic [IL-1:0] irqPrio;
  logic [DW-1:0] irqVector;
  logic          irqAck;
  logic [DW-1:0] pc;
  logic          retReq;
  logic [IL-1:0] level;
  logic          writeRaEn;
  logic [DW-1:0] writeRaData;
  logic          pcLoadEn;
  logic [DW-1:0] pcLoadData;
  logic [IL-1:0] depth;
  logic          retErr;

  level_ctrl #(.DataWidth(DW), .NumLevels(NL), .RaMagic(MAGIC)) dut (
    .clk(clk), .reset(reset), .irqReq(irqReq), .irqPrio(irqPrio),
    .irqVector(irqVector), .irqAck(irqAck), .pc(pc), .retReq(retReq),
    .level(level), .writeRaEn(writeRaEn), .writeRaData(writeRaData),
    .pcLoadEn(pcLoadEn), .pcLoadData(pcLoadData), .depth(depth),
    .retErr(retErr)
  );

  always #5 clk = ~clk;

  // Reference model: current level and a stack of interrupted contexts.
  typedef struct {
    int          lvl;
    logic [31:0] pcv;
  } ctx_t;

  ctx_t m_stack[$];
  int   m_level;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, 32'(irqAck), 32'd0);
    chk({tag, "_pcl"}, 32'(pcLoadEn), 32'd0);
    chk({tag, "_wra"}, 32'(writeRaEn), 32'd0);
    chk({tag, "_err"}, 32'(retErr), 32'd0);
  endtask

  task automatic do_irq(input int prio, input logic [31:0] vec, input logic [31:0] pcv);
    bit acc;
    acc       = prio > m_level;
    irqReq    = 1'b1;
    irqPrio   = IL'(prio);
    irqVector = vec;
    pc        = pcv;
    tick();
    irqReq    = 1'b0;
    irqPrio   = IL'($urandom);
    irqVector = $urandom;
    chk("irq_ack", 32'(irqAck), 32'(acc));
    chk("irq_lvl_hold", 32'(level), 32'(m_level));
    if (acc) begin
      m_stack.push_back('{lvl: m_level, pcv: pcv});
      chk("irq_depth", 32'(depth), 32'(m_stack.size()));
      tick();
      m_level = prio;
      chk("enter_lvl", 32'(level), 32'(m_level));
      chk("enter_wra", 32'(writeRaEn), 32'd1);
      chk("enter_wrd", writeRaData, MAGIC);
      chk("enter_pcl", 32'(pcLoadEn), 32'd1);
      chk("enter_pcd", pcLoadData, vec);
      chk("enter_ack", 32'(irqAck), 32'd0);
      chk("enter_depth", 32'(depth), 32'(m_stack.size()));
    end else begin
      chk("mask_pcl", 32'(pcLoadEn), 32'd0);
      chk("mask_depth", 32'(depth), 32'(m_stack.size()));
    end
    tick();
    chk_quiet("irq_after");
  endtask

  task automatic do_ret(input bit with_irq, input int prio, input logic [31:0] vec);
    ctx_t top;
    bit   tail;
    retReq    = 1'b1;
    irqReq    = with_irq;
    irqPrio   = IL'(prio);
    irqVector = vec;
    tick();
    retReq = 1'b0;
    if (m_stack.size() == 0) begin
      irqReq = 1'b0;
      chk("reterr_pulse", 32'(retErr), 32'd1);
      chk("reterr_pcl", 32'(pcLoadEn), 32'd0);
      chk("reterr_ack", 32'(irqAck), 32'd0);
      chk("reterr_depth", 32'(depth), 32'd0);
      tick();
      chk_quiet("reterr_after");
      return;
    end
    top  = m_stack[$];
    tail = 1'b0;
`ifdef LEVEL_CTRL_TAIL_CHAIN_EN
    tail = with_irq && (prio > top.lvl);
`endif
    chk("ret_err", 32'(retErr), 32'd0);
    if (tail) begin
      irqReq = 1'b0;
      chk("tail_ack", 32'(irqAck), 32'd1);
      chk("tail_depth", 32'(depth), 32'(m_stack.size()));
      tick();
      m_level = prio;
      chk("tail_lvl", 32'(level), 32'(m_level));
      chk("tail_pcl", 32'(pcLoadEn), 32'd1);
      chk("tail_pcd", pcLoadData, vec);
      chk("tail_wra", 32'(writeRaEn), 32'd1);
      chk("tail_wrd", writeRaData, MAGIC);
      chk("tail_depth2", 32'(depth), 32'(m_stack.size()));
    end else begin
      chk("ret_ack", 32'(irqAck), 32'd0);
      void'(m_stack.pop_back());
      chk("ret_depth", 32'(depth), 32'(m_stack.size()));
      // Any held request is not looked at during the exit cycle.
      tick();
      irqReq  = 1'b0;
      m_level = top.lvl;
      chk("exit_lvl", 32'(level), 32'(m_level));
      chk("exit_pcl", 32'(pcLoadEn), 32'd1);
      chk("exit_pcd", pcLoadData, top.pcv);
      chk("exit_wra", 32'(writeRaEn), 32'd0);
      chk("exit_ack", 32'(irqAck), 32'd0);
      chk("exit_depth", 32'(depth), 32'(m_stack.size()));
    end
    tick();
    chk_quiet("ret_after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    irqReq    = 1'b0;
    irqPrio   = '0;
    irqVector = '0;
    pc        = '0;
    retReq    = 1'b0;
    m_level   = 0;
    #12;
    chk("rst_lvl", 32'(level), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_wrd", writeRaData, 32'd0);
    chk("rst_pcd", pcLoadData, 32'd0);
    chk_quiet("rst");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_quiet("idle");

    // Entry, nesting and unwind.
    do_irq(3, 32'h400, 32'h100);
    do_irq(5, 32'h500, 32'h420);
    do_ret(1'b0, 0, 32'h0);
    do_ret(1'b0, 0, 32'h0);
    // Return with nothing stacked.
    do_ret(1'b0, 0, 32'h0);

    // Masking at level 3.
    do_irq(3, 32'h400, 32'h100);
    do_irq(3, 32'h700, 32'h404);
    do_irq(2, 32'h710, 32'h408);

    // Simultaneous return and higher-priority request.
    do_ret(1'b1, 6, 32'h600);
`ifndef LEVEL_CTRL_TAIL_CHAIN_EN
    do_irq(6, 32'h600, 32'h100);
`endif
    do_ret(1'b0, 0, 32'h0);

    // Priority 0 at thread level is never accepted.
    do_irq(0, 32'h800, 32'h200);

    // Reset in the middle of an entry.
    irqReq    = 1'b1;
    irqPrio   = IL'(4);
    irqVector = 32'h900;
    pc        = 32'h300;
    tick();
    irqReq = 1'b0;
    chk("pre_rst_ack", 32'(irqAck), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    m_stack.delete();
    m_level = 0;
    chk("midrst_lvl", 32'(level), 32'd0);
    chk("midrst_depth", 32'(depth), 32'd0);
    chk_quiet("midrst");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("postrst_lvl", 32'(level), 32'd0);
    chk_quiet("postrst");

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      if (m_stack.size() != 0 && $urandom_range(0, 2) == 0)
        do_ret(1'($urandom_range(0, 1)), int'($urandom_range(0, NL - 1)), $urandom);
      else if ($urandom_range(0, 15) == 0)
        do_ret(1'b0, 0, 32'h0);
      else
        do_irq(int'($urandom_range(0, NL - 1)), $urandom, $urandom);
    end
    while (m_stack.size() != 0) do_ret(1'b0, 0, 32'h0);
    chk("final_lvl", 32'(level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
